// File: rtl/inst_encoder_pkg.sv
// Shared instruction-format constants: TYPE_* codes, base opcodes, and the
// opcode -> expected format mapping used by the encoder's legality check.
package inst_encoder_pkg;

    localparam logic [2:0] TYPE_NONE = 3'd0;
    localparam logic [2:0] TYPE_R    = 3'd1;
    localparam logic [2:0] TYPE_I    = 3'd2;
    localparam logic [2:0] TYPE_S    = 3'd3;
    localparam logic [2:0] TYPE_B    = 3'd4;
    localparam logic [2:0] TYPE_U    = 3'd5;
    localparam logic [2:0] TYPE_J    = 3'd6;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } enc_word_t;

    // Unknown opcodes map to TYPE_NONE so they can never match a real format.
    function automatic logic [2:0] opcode_type(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC:                     return TYPE_U;
            OPC_JAL:                                return TYPE_J;
            OPC_BRANCH:                             return TYPE_B;
            OPC_LOAD, OPC_OP_IMM, OPC_JALR,
            OPC_MISC_MEM, OPC_SYSTEM:               return TYPE_I;
            OPC_STORE:                              return TYPE_S;
            OPC_OP:                                 return TYPE_R;
            default:                                return TYPE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational field packing and immediate range checking for one bundle.
module inst_pack
    import inst_encoder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      itype,
    input  logic [6:0]      opcode,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] imm,
    output logic [31:0]     inst,
    output logic            err
);

    logic sx12_ok, sx13_ok, sx21_ok, range_err;

    // Immediate must equal the sign-extension of its low N bits.
    assign sx12_ok = (imm == XLEN'($signed(imm[11:0])));
    assign sx13_ok = (imm == XLEN'($signed(imm[12:0])));
    assign sx21_ok = (imm == XLEN'($signed(imm[20:0])));

    always_comb begin
        inst      = '0;
        range_err = 1'b0;
        case (itype)
            TYPE_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
            TYPE_I: begin
                inst      = {imm[11:0], rs1, funct3, rd, opcode};
                range_err = !sx12_ok;
            end
            TYPE_S: begin
                inst      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_err = !sx12_ok;
            end
            TYPE_B: begin
                inst      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_err = !sx13_ok || imm[0];
            end
            TYPE_U: begin
                inst      = {imm[31:12], rd, opcode};
                range_err = (imm[11:0] != 12'd0);
            end
            TYPE_J: begin
                inst      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                range_err = !sx21_ok || imm[0];
            end
            default: range_err = 1'b1;
        endcase
    end

    assign err = range_err || (opcode_type(opcode) != itype);

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: packs a decoded field bundle into a 32-bit word and
// queues it in a 2-entry FIFO, counting illegal bundles (saturating).
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_itype,
    input  logic [6:0]      in_opcode,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic            out_err,
    output logic [7:0]      err_count
);

    logic [31:0] pk_inst;
    logic        pk_err;

    inst_pack #(.XLEN(XLEN)) u_pack (
        .itype  (in_itype),
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .inst   (pk_inst),
        .err    (pk_err)
    );

    enc_word_t  mem_q [FIFO_DEPTH];
    enc_word_t  mem_d [FIFO_DEPTH];
    logic       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic [7:0] err_count_q, err_count_d;
    logic       push, pop;

    // Ready depends only on occupancy, never on out_ready.
    assign in_ready  = (count_q != 2'(FIFO_DEPTH));
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_count_d = err_count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{inst: pk_inst, err: pk_err};
            wr_ptr_d        = ~wr_ptr_q;
            if (pk_err && err_count_q != 8'hFF)
                err_count_d = err_count_q + 8'd1;
        end
        if (pop)
            rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            err_count_q <= 8'd0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_inst  = out_valid ? mem_q[rd_ptr_q].inst : 32'd0;
    assign out_err   = out_valid ? mem_q[rd_ptr_q].err  : 1'b0;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-encoded words, backpressure, saturation, reset.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [2:0]  in_itype;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid, out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    inst_encoder #(.XLEN(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_itype  (in_itype),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] t, input logic [6:0] opc, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        in_itype = t; in_opcode = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One-cycle offer with out_ready=1, then check the word one cycle after accept.
    task automatic send_chk(input string tag, input logic [2:0] t, input logic [6:0] opc,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                            input logic [31:0] exp_inst, input logic exp_err);
        drive(t, opc, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_inst"}, out_inst, exp_inst);
        chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(TYPE_NONE, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        #10 reset_n = 1'b1;
        step();

        send_chk("addi", TYPE_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
        send_chk("sw", TYPE_S, OPC_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 1'b0);
        send_chk("jal", TYPE_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF, 1'b0);
        send_chk("add", TYPE_R, OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b0);
        send_chk("addi_neg", TYPE_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        send_chk("beq", TYPE_B, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd16, 32'h00208863, 1'b0);
        chk("err_count_clean", 32'(err_count), 32'd0);
        send_chk("lui_bad", TYPE_U, OPC_LUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h123450B7, 1'b1);
        chk("err_count_1", 32'(err_count), 32'd1);
        send_chk("itype0", TYPE_NONE, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0, 1'b1);
        send_chk("beq_odd", TYPE_B, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd17, 32'h00208863, 1'b1);
        send_chk("mismatch", TYPE_I, OPC_OP, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h005000B3, 1'b1);
        send_chk("addi_2048", TYPE_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80000093, 1'b1);
        chk("err_count_5", 32'(err_count), 32'd5);
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);

        // Backpressure: two accepted, third blocked, then drained in order.
        out_ready = 1'b0;
        drive(TYPE_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        in_valid = 1'b1;
        chk("bp_ready0", 32'(in_ready), 32'd1);
        step();
        chk("bp_w1_head", out_inst, 32'h00100093);
        drive(TYPE_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        step();
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        drive(TYPE_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        step();
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk("bp_hold", out_inst, 32'h00100093);
        out_ready = 1'b1;
        step();
        chk("drain_w2", out_inst, 32'h00200093);
        chk("drain_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("drain_w3", out_inst, 32'h00300093);
        step();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Saturation: 260 illegal bundles on top of the 5 already counted.
        drive(TYPE_NONE, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 260; i++) step();
        in_valid = 1'b0;
        chk("err_sat", 32'(err_count), 32'd255);
        step();

        // Reset with the FIFO full, checked between clock edges.
        out_ready = 1'b0;
        drive(TYPE_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_errcnt", 32'(err_count), 32'd0);
        chk("mid_rst_inst", out_inst, 32'd0);
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        chk("post_rst_empty", 32'(out_valid), 32'd0);
        send_chk("post_rst", TYPE_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
        step();
        chk("post_rst_drained", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
